cache_op_sequencer: RTL and testbench

Top-level operation sequencer for the Redis cache controller. Accepts one host command at a time over a valid/ready interface and decodes its 3-bit operation code. Starts the matching GET, UPSERT or DELETE sub-unit and waits for that unit's done/error status, with a watchdog timeout. Returns one response per command over a valid/ready interface.

---
 rtl/cache_op_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_cache_op_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_op_sequencer.sv
// Operation sequencer for the cache controller: decodes one host command, starts the
// matching GET/UPSERT/DELETE unit, waits for it under a watchdog and returns a response.
module cache_op_sequencer #(
  parameter int KEY_W          = 32,
  parameter int VAL_W          = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [KEY_W-1:0] req_key_i,
  input  logic [VAL_W-1:0] req_value_i,
  output logic             get_start_o,
  output logic             upsert_start_o,
  output logic             del_start_o,
  output logic [KEY_W-1:0] sub_key_o,
  output logic [VAL_W-1:0] sub_value_o,
  input  logic [1:0]       get_status_i,
  input  logic [1:0]       upsert_status_i,
  input  logic [1:0]       del_status_i,
  input  logic [VAL_W-1:0] get_rdata_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_error_o,
  output logic             resp_timeout_o,
  output logic [VAL_W-1:0] resp_rdata_o,
  output logic             busy_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GET    = 3'd1,
    ST_UPSERT = 3'd2,
    ST_DEL    = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  // Counter value seen in the last post-start cycle before the watchdog fires.
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_reg, state_next;
  logic               first_reg, first_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [KEY_W-1:0]   key_reg, key_next;
  logic [VAL_W-1:0]   value_reg, value_next;
  logic               resp_valid_reg, resp_valid_next;
  logic               resp_error_reg, resp_error_next;
  logic               resp_timeout_reg, resp_timeout_next;
  logic [VAL_W-1:0]   resp_rdata_reg, resp_rdata_next;
  logic [1:0]         act_status;
  logic               accept;
  logic               expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      first_reg        <= 1'b0;
      cnt_reg          <= '0;
      key_reg          <= '0;
      value_reg        <= '0;
      resp_valid_reg   <= 1'b0;
      resp_error_reg   <= 1'b0;
      resp_timeout_reg <= 1'b0;
      resp_rdata_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      first_reg        <= first_next;
      cnt_reg          <= cnt_next;
      key_reg          <= key_next;
      value_reg        <= value_next;
      resp_valid_reg   <= resp_valid_next;
      resp_error_reg   <= resp_error_next;
      resp_timeout_reg <= resp_timeout_next;
      resp_rdata_reg   <= resp_rdata_next;
    end
  end

  assign req_ready_o = (state_reg == ST_IDLE) && !resp_valid_reg;
  assign accept      = req_valid_i && req_ready_o;
  assign expire      = (TIMEOUT_CYCLES != 0) && (cnt_reg == TO_LAST);

  // Only the unit owned by the current state is listened to.
  always_comb begin
    act_status = 2'b00;
    case (state_reg)
      ST_GET:    act_status = get_status_i;
      ST_UPSERT: act_status = upsert_status_i;
      ST_DEL:    act_status = del_status_i;
      default:   act_status = 2'b00;
    endcase
  end

  always_comb begin
    state_next        = state_reg;
    first_next        = first_reg;
    cnt_next          = cnt_reg;
    key_next          = key_reg;
    value_next        = value_reg;
    resp_valid_next   = resp_valid_reg;
    resp_error_next   = resp_error_reg;
    resp_timeout_next = resp_timeout_reg;
    resp_rdata_next   = resp_rdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (resp_valid_reg && resp_ready_i) begin
          resp_valid_next   = 1'b0;
          resp_error_next   = 1'b0;
          resp_timeout_next = 1'b0;
          resp_rdata_next   = '0;
        end
        if (accept) begin
          key_next   = req_key_i;
          value_next = req_value_i;
          first_next = 1'b1;
          cnt_next   = '0;
          case (req_op_i)
            3'b000: begin
              resp_valid_next   = 1'b1;
              resp_error_next   = 1'b0;
              resp_timeout_next = 1'b0;
              resp_rdata_next   = '0;
            end
            3'b001:  state_next = ST_GET;
            3'b010:  state_next = ST_UPSERT;
            3'b011:  state_next = ST_DEL;
            default: begin
              state_next        = ST_ERR;
              resp_valid_next   = 1'b1;
              resp_error_next   = 1'b1;
              resp_timeout_next = 1'b0;
              resp_rdata_next   = '0;
            end
          endcase
        end
      end

      ST_GET, ST_UPSERT, ST_DEL: begin
        first_next = 1'b0;
        // The start cycle ignores status; error outranks done, and any status outranks expiry.
        if (!first_reg) begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (act_status[0]) begin
            state_next        = ST_ERR;
            resp_valid_next   = 1'b1;
            resp_error_next   = 1'b1;
            resp_timeout_next = 1'b0;
            resp_rdata_next   = '0;
          end else if (act_status[1]) begin
            state_next        = ST_IDLE;
            resp_valid_next   = 1'b1;
            resp_error_next   = 1'b0;
            resp_timeout_next = 1'b0;
            resp_rdata_next   = (state_reg == ST_GET) ? get_rdata_i : '0;
          end else if (expire) begin
            state_next        = ST_ERR;
            resp_valid_next   = 1'b1;
            resp_error_next   = 1'b1;
            resp_timeout_next = 1'b1;
            resp_rdata_next   = '0;
          end
        end
      end

      ST_ERR: begin
        if (resp_ready_i) begin
          state_next        = ST_IDLE;
          resp_valid_next   = 1'b0;
          resp_error_next   = 1'b0;
          resp_timeout_next = 1'b0;
          resp_rdata_next   = '0;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign get_start_o    = (state_reg == ST_GET)    && first_reg;
  assign upsert_start_o = (state_reg == ST_UPSERT) && first_reg;
  assign del_start_o    = (state_reg == ST_DEL)    && first_reg;
  assign sub_key_o      = key_reg;
  assign sub_value_o    = value_reg;
  assign resp_valid_o   = resp_valid_reg;
  assign resp_error_o   = resp_error_reg;
  assign resp_timeout_o = resp_timeout_reg;
  assign resp_rdata_o   = resp_rdata_reg;
  assign busy_o         = (state_reg != ST_IDLE);
  assign state_o        = state_reg;

endmodule

// File: tb/tb_cache_op_sequencer.sv
// Bench for cache_op_sequencer: directed plan steps plus random commands, each checked
// against an outcome model computed from op code, status arrival cycle and watchdog limit.
module tb_cache_op_sequencer;
  localparam int KEY_W = 32;
  localparam int VAL_W = 64;
  localparam int TO    = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [2:0]       req_op_i = '0;
  logic [KEY_W-1:0] req_key_i = '0;
  logic [VAL_W-1:0] req_value_i = '0;
  logic             get_start_o, upsert_start_o, del_start_o;
  logic [KEY_W-1:0] sub_key_o;
  logic [VAL_W-1:0] sub_value_o;
  logic [1:0]       get_status_i = '0, upsert_status_i = '0, del_status_i = '0;
  logic [VAL_W-1:0] get_rdata_i = '0;
  logic             resp_valid_o;
  logic             resp_ready_i = 1'b0;
  logic             resp_error_o, resp_timeout_o;
  logic [VAL_W-1:0] resp_rdata_o;
  logic             busy_o;
  logic [2:0]       state_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_op_sequencer #(
    .KEY_W(KEY_W), .VAL_W(VAL_W), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_key_i(req_key_i), .req_value_i(req_value_i),
    .get_start_o(get_start_o), .upsert_start_o(upsert_start_o), .del_start_o(del_start_o),
    .sub_key_o(sub_key_o), .sub_value_o(sub_value_o),
    .get_status_i(get_status_i), .upsert_status_i(upsert_status_i), .del_status_i(del_status_i),
    .get_rdata_i(get_rdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_error_o(resp_error_o),
    .resp_timeout_o(resp_timeout_o), .resp_rdata_o(resp_rdata_o),
    .busy_o(busy_o), .state_o(state_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command: op, key, value, post-start cycle k at which status s arrives, GET data,
  // cycles to hold resp_ready_i low, and whether resp_ready_i is tied high throughout.
  task automatic run_cmd(input logic [2:0] op, input logic [31:0] key, input logic [63:0] val,
                         input int k, input logic [1:0] s, input logic [63:0] rd,
                         input int hold, input bit tied);
    int cyc, pulses, pulse_cyc, exp_cyc, exp_pulses;
    bit got;
    logic exp_err, exp_to;
    logic [63:0] exp_rd;
    logic [2:0] seen, exp_mask, exp_state;
    logic [1:0] act;

    exp_mask = 3'b000;
    if (op == 3'd0) begin
      exp_cyc = 1; exp_err = 0; exp_to = 0; exp_rd = 0; exp_pulses = 0;
    end else if (op > 3'd3) begin
      exp_cyc = 1; exp_err = 1; exp_to = 0; exp_rd = 0; exp_pulses = 0;
    end else begin
      exp_pulses = 1;
      exp_mask = (op == 3'd1) ? 3'b100 : (op == 3'd2) ? 3'b010 : 3'b001;
      if (s != 2'b00 && k <= TO) begin
        exp_cyc = k + 2; exp_err = s[0]; exp_to = 0;
        exp_rd = (op == 3'd1 && s == 2'b10) ? rd : 64'd0;
      end else begin
        exp_cyc = TO + 2; exp_err = 1; exp_to = 1; exp_rd = 0;
      end
    end
    exp_state = exp_err ? 3'd4 : 3'd0;

    resp_ready_i = tied;
    cyc = 0;
    while (!req_ready_o && cyc < 20) begin @(negedge clk); cyc++; end
    check("ready_before_cmd", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_op_i = op; req_key_i = key; req_value_i = val;
    @(negedge clk);
    req_valid_i = 1'b0; req_op_i = 3'($urandom); req_key_i = $urandom;
    cyc = 1; got = 0; pulses = 0; pulse_cyc = 0; seen = 3'b000;
    while (!got && cyc < 40) begin
      if (get_start_o || upsert_start_o || del_start_o) begin
        pulses += int'(get_start_o) + int'(upsert_start_o) + int'(del_start_o);
        pulse_cyc = cyc;
        seen |= {get_start_o, upsert_start_o, del_start_o};
        check("sub_key_at_start", 64'(sub_key_o), 64'(key));
        check("sub_value_at_start", sub_value_o, val);
      end
      if (resp_valid_o) got = 1;
      else begin
        act = (cyc == 1) ? 2'($urandom) : ((cyc - 1 == k) ? s : 2'b00);
        get_status_i    = (op == 3'd1) ? act : 2'($urandom);
        upsert_status_i = (op == 3'd2) ? act : 2'($urandom);
        del_status_i    = (op == 3'd3) ? act : 2'($urandom);
        get_rdata_i     = (cyc - 1 == k) ? rd : {$urandom, $urandom};
        @(negedge clk);
        cyc++;
      end
    end
    check("resp_latency", 64'(cyc), 64'(exp_cyc));
    check("start_pulses", 64'(pulses), 64'(exp_pulses));
    check("start_unit", 64'(seen), 64'(exp_mask));
    check("start_cycle", 64'(pulse_cyc), 64'(exp_pulses));
    check("resp_error", 64'(resp_error_o), 64'(exp_err));
    check("resp_timeout", 64'(resp_timeout_o), 64'(exp_to));
    check("resp_rdata", resp_rdata_o, exp_rd);
    check("state_at_resp", 64'(state_o), 64'(exp_state));
    check("ready_at_resp", 64'(req_ready_o), 64'd0);
    if (!tied) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", 64'(resp_valid_o), 64'd1);
        check("hold_error", 64'(resp_error_o), 64'(exp_err));
        check("hold_timeout", 64'(resp_timeout_o), 64'(exp_to));
        check("hold_rdata", resp_rdata_o, exp_rd);
        check("hold_ready", 64'(req_ready_o), 64'd0);
        check("hold_pulses", 64'({get_start_o, upsert_start_o, del_start_o}), 64'd0);
      end
    end
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = tied;
    check("after_hs_valid", 64'(resp_valid_o), 64'd0);
    check("after_hs_ready", 64'(req_ready_o), 64'd1);
    check("after_hs_state", 64'(state_o), 64'd0);
    $display("cmd op=%0d key=%h k=%0d s=%b tied=%0d -> lat=%0d err=%0d to=%0d rdata=%h",
             op, key, k, s, tied, cyc, resp_error_o, resp_timeout_o, exp_rd);
  endtask

  initial begin
    int stray;
    logic [2:0] rop;
    logic [1:0] rs;

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_valid", 64'(resp_valid_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(req_ready_o), 64'd1);
    check("idle_sub_key", 64'(sub_key_o), 64'd0);
    check("idle_pulses", 64'({get_start_o, upsert_start_o, del_start_o}), 64'd0);

    // Reset in the middle of a GET.
    req_valid_i = 1'b1; req_op_i = 3'd1; req_key_i = 32'hAAAA_0001;
    @(negedge clk);
    req_valid_i = 1'b0;
    check("midrst_start", 64'(get_start_o), 64'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_state", 64'(state_o), 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_valid", 64'(resp_valid_o), 64'd0);
    check("midrst_ready", 64'(req_ready_o), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    get_status_i = 2'b10;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      stray += int'(get_start_o) + int'(upsert_start_o) + int'(del_start_o) + int'(resp_valid_o);
    end
    get_status_i = 2'b00;
    check("midrst_no_activity", 64'(stray), 64'd0);
    $display("reset mid-GET: stray events=%0d", stray);

    run_cmd(3'd1, 32'h0000_1234, 64'h0, 3, 2'b10, 64'h0000_0000_DEAD_BEEF, 4, 0);
    run_cmd(3'd2, 32'h0000_5678, 64'h1111_2222_3333_4444, 2, 2'b11, 64'h0, 1, 0);
    run_cmd(3'd3, 32'h0000_9ABC, 64'h0, 1, 2'b01, 64'h0, 0, 0);
    run_cmd(3'd3, 32'h0000_0D0D, 64'h0, 99, 2'b00, 64'h0, 1, 0);
    run_cmd(3'd3, 32'h0000_0E0E, 64'h0, TO, 2'b10, 64'h0, 0, 0);
    run_cmd(3'd2, 32'h0000_0F0F, 64'h5, TO + 1, 2'b10, 64'h0, 0, 0);
    run_cmd(3'd0, 32'h0000_0001, 64'h0, 1, 2'b10, 64'h0, 2, 0);
    run_cmd(3'b101, 32'h0000_0002, 64'h0, 1, 2'b10, 64'h0, 2, 0);
    run_cmd(3'd1, 32'hB2B2_0001, 64'h0, 2, 2'b10, 64'hCAFE_F00D_0000_0001, 0, 1);
    run_cmd(3'd2, 32'hB2B2_0002, 64'h77, 1, 2'b10, 64'h0, 0, 1);
    run_cmd(3'd3, 32'hB2B2_0003, 64'h0, 4, 2'b10, 64'h0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      rop = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 3)) : 3'($urandom);
      rs  = 2'($urandom);
      run_cmd(rop, $urandom, {$urandom, $urandom}, $urandom_range(1, TO + 2), rs,
              {$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
